stack_downstream_dispatcher: RTL and testbench
==============================================

// Module: stack_downstream_dispatcher
// PURPOSE
//  Scheduler between the downstream stack bus and the PE's consumers. Buffers stack-bus beats in a FIFO,
//  decodes each packet header and routes the whole packet, locked until EOP, to the local controller
//  (control packets) or to one streaming-op lane (data packets). Handles per-destination backpressure,
//  drops malformed packets and reports protocol errors. Sits inside the PE stack interface.
// PARAMETERS
//  DATA_W       64  beat data width
//  NUM_LANES    2   streaming-op lanes
//  LANE_ID_W    2   header lane-id width; ids >= NUM_LANES are illegal
//  FIFO_DEPTH   8   input FIFO entries, power of 2, >= 2
//  TIMEOUT_CYC  256 stall watchdog limit; used only with STACK_DISPATCH_TIMEOUT_EN
// PORTS
//  clk               in  1                 clock
//  reset_poweron     in  1                 asynchronous, active-low reset
//  std__pe__valid    in  1                 stack-bus beat valid
//  std__pe__cntl     in  2                 framing: 01 SOP, 00 MOP, 10 EOP, 11 SOM (single-beat pkt)
//  std__pe__type     in  2                 header type, sampled on SOP/SOM: 00 data, 01 control, others illegal
//  std__pe__lane     in  LANE_ID_W         destination lane, sampled on SOP/SOM of data packets
//  std__pe__data     in  DATA_W            beat payload
//  pe__std__ready    out 1                 FIFO can accept a beat
//  sti__cntl__valid  out 1                 beat to local controller
//  sti__cntl__cntl   out 2                 framing of that beat
//  sti__cntl__data   out DATA_W            payload
//  cntl__sti__ready  in  1                 controller accepts
//  sti__stOp__valid  out NUM_LANES         per-lane beat valid
//  sti__stOp__cntl   out 2*NUM_LANES       per-lane framing
//  sti__stOp__data   out DATA_W*NUM_LANES  per-lane payload
//  stOp__sti__ready  in  NUM_LANES         per-lane accept
//  sti__err_pulse    out 1                 one-cycle protocol-error strobe
//  sti__pkt_count    out 16                packets fully delivered (EOP/SOM accepted)
// BEHAVIOUR
//  - Reset: FIFO empty, FSM IDLE, all valids 0, pe__std__ready 0, err 0, pkt_count 0.
//    pe__std__ready rises on the first clock edge after reset release.
//  - Input: a beat is written when valid & ready. ready = !full, driven from the registered count.
//    A simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Latency: a beat written at edge N is at the FIFO head and drives an output from cycle N+1.
//  - Output: valid, cntl and data are combinational from the FIFO head and FSM state.
//    The head pops only when the selected destination's ready is 1. Non-selected valids stay 0.
//  - FSM states: IDLE, CNTL, LANE, DROP.
//    IDLE + head SOP:    type 01 -> CNTL; type 00 with lane<NUM_LANES -> LANE (lane latched);
//                        anything else -> DROP with err pulse. The SOP beat itself is routed in the new state.
//    IDLE + head SOM:    routed like SOP, but FSM returns to IDLE when the beat pops; illegal SOM is popped with err.
//    IDLE + head MOP/EOP: beat popped, discarded, err pulse.
//    CNTL/LANE:          beats forwarded; EOP pop -> IDLE.
//    SOP/SOM mid-packet: err pulse. The current packet is abandoned (the beat is not forwarded) and the
//                        beat is re-decoded as in IDLE on the next cycle.
//    DROP:               pops one beat per cycle unconditionally; EOP -> IDLE.
//  - pkt_count increments when an EOP or SOM beat is accepted by a destination; it wraps 0xFFFF -> 0.
//    Dropped packets do not count.
//  - Reset mid-packet: everything is cleared immediately. Partial packets are lost and no EOP is emitted.
// CONFIGURATION
//  STACK_DISPATCH_TIMEOUT_EN defined:
//    - In CNTL or LANE, a counter increments each cycle no beat pops and clears on any pop.
//    - At TIMEOUT_CYC the FSM goes to DROP, emits an err pulse and the counter clears.
//    - The remainder of the packet is discarded.
//  Undefined: no watchdog logic; CNTL/LANE wait on ready indefinitely.
// TESTING
//  1. Ctrl pkt SOP,MOP,EOP (type 01), cntl ready=1 -> 3 beats on sti__cntl__*, first beat 1 cycle after input; pkt_count=1.
//  2. Data SOM lane 1, stOp ready[1]=0 for 5 cycles -> valid[1] held 5 cycles with data stable, valid[0]=0, pops on ready.
//  3. 9 beats back-to-back, all destination readies 0, FIFO_DEPTH 8 -> ready drops after the 8th beat; no loss after release.
//  4. Data SOP lane 3 (NUM_LANES=2), 4-beat pkt -> err pulse once, no output valids, pkt_count unchanged.
//  5. SOP,MOP then SOP,EOP (ctrl) -> err pulse at the second SOP; second packet delivered whole to controller.
//  6. Reset asserted mid-packet in LANE -> all valids 0 immediately; after release, a new SOM routes normally.
//     With STACK_DISPATCH_TIMEOUT_EN: ready[0]=0 for 256 cycles in LANE -> err pulse, remainder dropped.

Source files
------------

// File: rtl/stack_downstream_dispatcher.sv
// stack_downstream_dispatcher: FIFO-buffered packet router from the stack bus to the controller or a streaming lane.
// Optional stall watchdog is enabled by defining STACK_DISPATCH_TIMEOUT_EN.
module stack_downstream_dispatcher #(
    parameter int DATA_W      = 64,
    parameter int NUM_LANES   = 2,
    parameter int LANE_ID_W   = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic                        std__pe__valid,
    input  logic [1:0]                  std__pe__cntl,
    input  logic [1:0]                  std__pe__type,
    input  logic [LANE_ID_W-1:0]        std__pe__lane,
    input  logic [DATA_W-1:0]           std__pe__data,
    output logic                        pe__std__ready,
    output logic                        sti__cntl__valid,
    output logic [1:0]                  sti__cntl__cntl,
    output logic [DATA_W-1:0]           sti__cntl__data,
    input  logic                        cntl__sti__ready,
    output logic [NUM_LANES-1:0]        sti__stOp__valid,
    output logic [2*NUM_LANES-1:0]      sti__stOp__cntl,
    output logic [DATA_W*NUM_LANES-1:0] sti__stOp__data,
    input  logic [NUM_LANES-1:0]        stOp__sti__ready,
    output logic                        sti__err_pulse,
    output logic [15:0]                 sti__pkt_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + LANE_ID_W + 4;
    localparam logic [LANE_ID_W:0] LANES = (LANE_ID_W+1)'(NUM_LANES);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, CNTL, LANE, DROP} state_t;
    state_t state, nxt;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic started, push, pop, to_cntl, to_lane, err_now, h_valid;
    logic [1:0] h_cntl, h_type;
    logic [LANE_ID_W-1:0] h_lane, lane_q, dest_lane;
    logic [DATA_W-1:0] h_data;
    logic [NUM_LANES-1:0] lane_hit;

    assign {h_cntl, h_type, h_lane, h_data} = mem[rd_ptr];
    assign h_valid = count != '0;
    // ready stays low until the first edge after reset release
    assign pe__std__ready = started && count != FULL;
    assign push = std__pe__valid && pe__std__ready;
    assign dest_lane = state == IDLE ? h_lane : lane_q;
    assign sti__cntl__valid = to_cntl;
    assign sti__cntl__cntl = h_cntl;
    assign sti__cntl__data = h_data;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_hit[i] = dest_lane == LANE_ID_W'(i);
        assign sti__stOp__valid[i] = to_lane && lane_hit[i];
        assign sti__stOp__cntl[2*i +: 2] = h_cntl;
        assign sti__stOp__data[DATA_W*i +: DATA_W] = h_data;
    end

    // In IDLE the head header is decoded and routed in the same cycle it reaches the head
    always_comb begin
        to_cntl = 1'b0;
        to_lane = 1'b0;
        pop = 1'b0;
        err_now = 1'b0;
        nxt = state;
        if (h_valid) begin
            if (state == IDLE) begin
                if (h_cntl[0] && h_type == 2'b01) begin
                    to_cntl = 1'b1;
                    nxt = h_cntl[1] ? IDLE : CNTL;
                end else if (h_cntl[0] && h_type == 2'b00 && {1'b0, h_lane} < LANES) begin
                    to_lane = 1'b1;
                    nxt = h_cntl[1] ? IDLE : LANE;
                end else begin
                    pop = 1'b1;
                    err_now = 1'b1;
                    nxt = h_cntl == 2'b01 ? DROP : IDLE;
                end
            end else if (state == DROP) begin
                pop = 1'b1;
                nxt = h_cntl == 2'b10 ? IDLE : DROP;
            end else if (h_cntl[0]) begin
                err_now = 1'b1;
                nxt = IDLE;
            end else begin
                to_cntl = state == CNTL;
                to_lane = state == LANE;
                nxt = h_cntl[1] ? IDLE : state;
            end
            if (to_cntl || to_lane) begin
                pop = to_cntl ? cntl__sti__ready : |(lane_hit & stOp__sti__ready);
                nxt = pop ? nxt : state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {std__pe__cntl, std__pe__type, std__pe__lane, std__pe__data};
    end

`ifdef STACK_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd;
    logic stall, wd_hit;
    assign stall = (state == CNTL || state == LANE) && !pop && nxt == state;
    assign wd_hit = stall && wd == TW'(TIMEOUT_CYC - 1);
`endif

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            started <= 1'b0;
            lane_q <= '0;
            sti__err_pulse <= 1'b0;
            sti__pkt_count <= '0;
`ifdef STACK_DISPATCH_TIMEOUT_EN
            wd <= '0;
`endif
        end else begin
            started <= 1'b1;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == IDLE && to_lane) lane_q <= h_lane;
            if (pop && (to_cntl || to_lane) && h_cntl[1]) sti__pkt_count <= sti__pkt_count + 16'd1;
`ifdef STACK_DISPATCH_TIMEOUT_EN
            state <= wd_hit ? DROP : nxt;
            sti__err_pulse <= err_now || wd_hit;
            wd <= (stall && !wd_hit) ? wd + 1'b1 : '0;
`else
            state <= nxt;
            sti__err_pulse <= err_now;
`endif
        end
    end
endmodule

// File: tb/tb_stack_downstream_dispatcher.sv
// tb_stack_downstream_dispatcher: directed and randomized checks of the stack-bus dispatcher
// against a beat-stream reference model of the packet routing rules.
module tb_stack_downstream_dispatcher;
    localparam int DW = 64;
    localparam int NL = 2;
    localparam int LW = 2;
    localparam int D_IDLE = -2;
    localparam int D_DROP = -1;
    localparam int D_CNTL = 2;

    typedef struct packed {
        logic [1:0] cntl;
        logic [1:0] typ;
        logic [LW-1:0] lane;
        logic [DW-1:0] data;
    } beat_t;
    typedef logic [DW+1:0] obs_t;

    logic clk = 1'b0;
    logic reset_poweron = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] in_cntl = '0, in_type = '0;
    logic [LW-1:0] in_lane = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready;
    logic c_valid;
    logic [1:0] c_cntl;
    logic [DW-1:0] c_data;
    logic c_ready = 1'b0;
    logic [NL-1:0] l_valid;
    logic [2*NL-1:0] l_cntl;
    logic [DW*NL-1:0] l_data;
    logic [NL-1:0] l_ready = '0;
    logic err;
    logic [15:0] pkt_count;

    int n_tests = 0;
    int n_fail = 0;
    bit rand_rdy = 1'b0;
    obs_t obs_c[$], obs_l0[$], obs_l1[$];
    obs_t exp_c[$], exp_l0[$], exp_l1[$];
    int obs_err = 0, exp_err = 0, obs_any = 0;
    int m_dest = D_IDLE;
    logic [15:0] m_pkts = '0;

    always #5 clk = ~clk;

    stack_downstream_dispatcher dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .std__pe__valid(in_valid),
        .std__pe__cntl(in_cntl),
        .std__pe__type(in_type),
        .std__pe__lane(in_lane),
        .std__pe__data(in_data),
        .pe__std__ready(in_ready),
        .sti__cntl__valid(c_valid),
        .sti__cntl__cntl(c_cntl),
        .sti__cntl__data(c_data),
        .cntl__sti__ready(c_ready),
        .sti__stOp__valid(l_valid),
        .sti__stOp__cntl(l_cntl),
        .sti__stOp__data(l_data),
        .stOp__sti__ready(l_ready),
        .sti__err_pulse(err),
        .sti__pkt_count(pkt_count)
    );

    always @(negedge clk) begin
        if (reset_poweron) begin
            if (c_valid && c_ready) obs_c.push_back({c_cntl, c_data});
            if (l_valid[0] && l_ready[0]) obs_l0.push_back({l_cntl[1:0], l_data[DW-1:0]});
            if (l_valid[1] && l_ready[1]) obs_l1.push_back({l_cntl[3:2], l_data[2*DW-1:DW]});
            if (c_valid || |l_valid) obs_any++;
            if (err) obs_err++;
            if (int'(c_valid) + $countones(l_valid) > 1) begin
                n_tests++;
                n_fail++;
                $display("FAIL onehot_valid: cntl=%b lanes=%b, required at most one valid", c_valid, l_valid);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            c_ready = $urandom_range(0, 3) != 0;
            l_ready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
        end
    end

    // Reference: walks the accepted beat stream and applies the packet rules directly
    task automatic model(input beat_t b);
        obs_t o = {b.cntl, b.data};
        if (b.cntl[0] && m_dest >= 0) begin
            exp_err++;
            m_dest = D_IDLE;
        end
        if (m_dest == D_IDLE) begin
            if (!b.cntl[0]) begin
                exp_err++;
                return;
            end
            if (b.typ == 2'd1) m_dest = D_CNTL;
            else if (b.typ == 2'd0 && int'(b.lane) < NL) m_dest = int'(b.lane);
            else begin
                exp_err++;
                m_dest = (b.cntl == 2'b01) ? D_DROP : D_IDLE;
                return;
            end
        end
        if (m_dest == D_DROP) begin
            if (b.cntl == 2'b10) m_dest = D_IDLE;
            return;
        end
        if (m_dest == D_CNTL) exp_c.push_back(o);
        else if (m_dest == 0) exp_l0.push_back(o);
        else exp_l1.push_back(o);
        if (b.cntl[1]) begin
            m_pkts++;
            m_dest = D_IDLE;
        end
    endtask

    task automatic clear_all();
        obs_c.delete(); obs_l0.delete(); obs_l1.delete();
        exp_c.delete(); exp_l0.delete(); exp_l1.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    task automatic send(input beat_t b);
        int t = 0;
        in_valid = 1'b1;
        in_cntl = b.cntl;
        in_type = b.typ;
        in_lane = b.lane;
        in_data = b.data;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", in_ready, t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model(b);
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] typ, input logic [LW-1:0] lane, input int len,
                            input bit term, input int max_gap, output logic [DW-1:0] d[$]);
        d.delete();
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.typ = typ;
            b.lane = lane;
            b.data = {$urandom, $urandom};
            b.cntl = (len == 1 && term) ? 2'b11 : (i == 0) ? 2'b01 : (i == len - 1 && term) ? 2'b10 : 2'b00;
            d.push_back(b.data);
            send(b);
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        reset_poweron = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, c_valid, l_valid, err, pkt_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b cv=%b lv=%b err=%b pc=%0d, required all 0", in_ready, c_valid, l_valid, err, pkt_count);
        end
        reset_poweron = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_ctrl_packet();
        logic [15:0] pc0 = pkt_count;
        logic [DW-1:0] d[3];
        beat_t b;
        clear_all();
        c_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d[i] = {$urandom, $urandom};
            b = '{cntl: (i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00, typ: 2'b01, lane: '0, data: d[i]};
            send(b);
            if (i == 0) begin
                n_tests++;
                if ({c_valid, c_cntl, c_data} !== {1'b1, 2'b01, d[0]}) begin
                    n_fail++;
                    $display("FAIL ctrl_latency: v=%b cntl=%b data=%h, required 1 01 %h", c_valid, c_cntl, c_data, d[0]);
                end
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_c.size() != 3) begin
            n_fail++;
            $display("FAIL ctrl_beats: got %0d beats, required 3", obs_c.size());
        end
        for (int i = 0; i < 3 && i < obs_c.size(); i++) begin
            n_tests++;
            if (obs_c[i][DW-1:0] !== d[i]) begin
                n_fail++;
                $display("FAIL ctrl_data%0d: got %h, required %h", i, obs_c[i][DW-1:0], d[i]);
            end
        end
        n_tests++;
        if (pkt_count !== pc0 + 16'd1) begin
            n_fail++;
            $display("FAIL ctrl_pkt_count: got %0d, required %0d", pkt_count, pc0 + 16'd1);
        end
    endtask

    task automatic test_lane_hold();
        logic [15:0] pc0 = pkt_count;
        logic [DW-1:0] d[$];
        clear_all();
        c_ready = 1'b0;
        l_ready = 2'b00;
        send_pkt(2'b00, 2'd1, 1, 1'b1, 0, d);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (l_valid !== 2'b10 || l_cntl[3:2] !== 2'b11 || l_data[2*DW-1:DW] !== d[0] || c_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL lane_hold%0d: lv=%b cntl=%b data=%h cv=%b, required 10 11 %h 0", i, l_valid, l_cntl[3:2], l_data[2*DW-1:DW], c_valid, d[0]);
            end
            @(posedge clk); #1;
        end
        l_ready = 2'b10;
        @(posedge clk); #1;
        n_tests++;
        if (l_valid !== 2'b00 || obs_l1.size() != 1 || pkt_count !== pc0 + 16'd1) begin
            n_fail++;
            $display("FAIL lane_pop: lv=%b beats=%0d pc=%0d, required 00 1 %0d", l_valid, obs_l1.size(), pkt_count, pc0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d[9];
        beat_t b;
        clear_all();
        c_ready = 1'b0;
        l_ready = 2'b00;
        for (int i = 0; i < 9; i++) d[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            b = '{cntl: (i == 0) ? 2'b01 : 2'b00, typ: 2'b01, lane: '0, data: d[i]};
            send(b);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b after 8 beats, required 0", in_ready);
        end
        b = '{cntl: 2'b10, typ: 2'b01, lane: '0, data: d[8]};
        fork
            send(b);
            begin
                repeat (4) @(posedge clk);
                #1;
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_hold: ready=%b while stalled, required 0", in_ready);
                end
                c_ready = 1'b1;
            end
        join
        repeat (12) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_c.size() != 9) begin
            n_fail++;
            $display("FAIL b2b_beats: got %0d, required 9", obs_c.size());
        end
        for (int i = 0; i < 9 && i < obs_c.size(); i++) begin
            n_tests++;
            if (obs_c[i][DW-1:0] !== d[i]) begin
                n_fail++;
                $display("FAIL b2b_data%0d: got %h, required %h", i, obs_c[i][DW-1:0], d[i]);
            end
        end
    endtask

    task automatic test_bad_lane();
        logic [15:0] pc0 = pkt_count;
        int a0 = obs_any;
        logic [DW-1:0] d[$];
        clear_all();
        c_ready = 1'b1;
        l_ready = 2'b11;
        send_pkt(2'b00, 2'd3, 4, 1'b1, 0, d);
        repeat (6) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_err != 1 || obs_any != a0 || pkt_count !== pc0) begin
            n_fail++;
            $display("FAIL bad_lane: errs=%0d valids=%0d pc=%0d, required 1 0 %0d", obs_err, obs_any - a0, pkt_count, pc0);
        end
    endtask

    task automatic test_abandon();
        logic [15:0] pc0 = pkt_count;
        logic [DW-1:0] d1[$], d2[$];
        clear_all();
        c_ready = 1'b1;
        send_pkt(2'b01, '0, 2, 1'b0, 0, d1);
        send_pkt(2'b01, '0, 2, 1'b1, 0, d2);
        repeat (6) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_err != 1 || obs_c.size() != 4 || pkt_count !== pc0 + 16'd1) begin
            n_fail++;
            $display("FAIL abandon: errs=%0d beats=%0d pc=%0d, required 1 4 %0d", obs_err, obs_c.size(), pkt_count, pc0 + 16'd1);
        end
        else begin
            n_tests++;
            if (obs_c[2] !== {2'b01, d2[0]} || obs_c[3] !== {2'b10, d2[1]}) begin
                n_fail++;
                $display("FAIL abandon_second: got %h %h, required %h %h", obs_c[2], obs_c[3], {2'b01, d2[0]}, {2'b10, d2[1]});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d[$];
        beat_t b;
        l_ready = 2'b01;
        b = '{cntl: 2'b01, typ: 2'b00, lane: 2'd0, data: {$urandom, $urandom}};
        send(b);
        b = '{cntl: 2'b00, typ: 2'b00, lane: 2'd0, data: {$urandom, $urandom}};
        send(b);
        l_ready = 2'b00;
        n_tests++;
        if (l_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_pre: lv=%b, required 01", l_valid);
        end
        #2;
        reset_poweron = 1'b0;
        #1;
        n_tests++;
        if ({l_valid, c_valid, in_ready, pkt_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: lv=%b cv=%b ready=%b pc=%0d, required all 0", l_valid, c_valid, in_ready, pkt_count);
        end
        repeat (2) begin @(posedge clk); #1; end
        reset_poweron = 1'b1;
        m_dest = D_IDLE;
        m_pkts = '0;
        clear_all();
        @(posedge clk); #1;
        l_ready = 2'b10;
        send_pkt(2'b00, 2'd1, 1, 1'b1, 0, d);
        repeat (2) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_l1.size() != 1 || obs_l0.size() != 0 || pkt_count !== 16'd1 || obs_err != 0) begin
            n_fail++;
            $display("FAIL after_reset: l1=%0d l0=%0d pc=%0d errs=%0d, required 1 0 1 0", obs_l1.size(), obs_l0.size(), pkt_count, obs_err);
        end
        else begin
            n_tests++;
            if (obs_l1[0] !== {2'b11, d[0]}) begin
                n_fail++;
                $display("FAIL after_reset_data: got %h, required %h", obs_l1[0], {2'b11, d[0]});
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d[$];
        beat_t b;
        clear_all();
        rand_rdy = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int kind = $urandom_range(0, 9);
            int len = $urandom_range(1, 5);
            if (kind == 0) begin
                b = '{cntl: $urandom_range(0, 1) ? 2'b10 : 2'b00, typ: 2'($urandom), lane: 2'($urandom), data: {$urandom, $urandom}};
                send(b);
            end
            else if (kind == 1) send_pkt(2'($urandom_range(2, 3)), 2'($urandom), len, 1'b1, 2, d);
            else if (kind == 2) send_pkt(2'b00, 2'($urandom_range(2, 3)), len, 1'b1, 2, d);
            else if (kind == 3) send_pkt(2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), $urandom_range(2, 4), 1'b0, 2, d);
            else send_pkt(2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), len, 1'b1, 2, d);
        end
        send_pkt(2'b01, '0, 1, 1'b1, 0, d);
        repeat (80) begin @(posedge clk); #1; end
        rand_rdy = 1'b0;
        for (int q = 0; q < 3; q++) begin
            obs_t oq[$], eq[$];
            if (q == 0) begin oq = obs_c; eq = exp_c; end
            else if (q == 1) begin oq = obs_l0; eq = exp_l0; end
            else begin oq = obs_l1; eq = exp_l1; end
            n_tests++;
            if (oq.size() != eq.size()) begin
                n_fail++;
                $display("FAIL rand_count dest%0d: got %0d beats, required %0d", q, oq.size(), eq.size());
            end
            for (int i = 0; i < oq.size() && i < eq.size(); i++) begin
                n_tests++;
                if (oq[i] !== eq[i]) begin
                    n_fail++;
                    $display("FAIL rand_beat dest%0d[%0d]: got %h, required %h", q, i, oq[i], eq[i]);
                end
            end
        end
        n_tests++;
        if (obs_err != exp_err || pkt_count !== m_pkts) begin
            n_fail++;
            $display("FAIL rand_totals: errs=%0d pc=%0d, required %0d %0d", obs_err, pkt_count, exp_err, m_pkts);
        end
    endtask

`ifdef STACK_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        beat_t b;
        c_ready = 1'b1;
        l_ready = 2'b11;
        b = '{cntl: 2'b01, typ: 2'b00, lane: 2'd0, data: {$urandom, $urandom}};
        send(b);
        @(posedge clk); #1;
        l_ready = 2'b00;
        obs_err = 0;
        n0 = obs_l0.size();
        for (int i = 0; i < 3; i++) begin
            b = '{cntl: (i == 2) ? 2'b10 : 2'b00, typ: 2'b00, lane: 2'd0, data: {$urandom, $urandom}};
            send(b);
        end
        repeat (280) @(posedge clk);
        #1;
        l_ready = 2'b11;
        repeat (5) begin @(posedge clk); #1; end
        n_tests++;
        if (obs_err != 1 || obs_l0.size() != n0) begin
            n_fail++;
            $display("FAIL timeout: errs=%0d extra_beats=%0d, required 1 0", obs_err, obs_l0.size() - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ctrl_packet();
        test_lane_hold();
        test_back_to_back();
        test_bad_lane();
        test_abandon();
        test_reset_mid();
        test_random();
`ifdef STACK_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
